// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Builds RV32 I, I-load, S and B instruction words from their separate fields.
// The words are streamed into instruction memory through a one-entry output
// buffer and a write-address counter. The 12-bit immediate taken in is the
// value the pipeline's immediate generator extracts from the produced word.
// B-type immediates are therefore in halfword units.
//
// Optional feature macro: IMM_RANGE_CHECK_EN
//   defined   : requests whose i_Imm does not fit in 12 signed bits are
//               handshaken but dropped, and o_Error is set (sticky).
//   undefined : i_Imm[11:0] is used as-is and o_Error is tied to 0.
//
// Parameters
//   WORD_SIZE    instruction / data / address width (>= 32)
//   BASE_ADDR    byte address of the first word written
//   DEPTH_WORDS  memory depth in words, power of two (>= 2)
//
// Ports
//   i_Clk, i_Reset    rising-edge clock, asynchronous active-high reset
//   i_Flush           synchronous clear of buffer, address, count and error
//   i_Valid/o_Ready   encode request handshake
//   i_Format          00 I, 01 I-load, 10 S, 11 B
//   i_Rd/i_Rs1/i_Rs2  register fields
//   i_Funct3          funct3 field
//   i_Imm             signed immediate
//   o_MemWrite/i_MemReady  memory write handshake
//   o_MemAddress      byte address of the buffered word
//   o_MemData         encoded instruction
//   o_Count           words written since reset/flush, saturates at DEPTH_WORDS
//   o_Wrapped         sticky, address counter has wrapped
//   o_Error           sticky, out-of-range immediate seen
// -----------------------------------------------------------------------------
module instr_encoder #(
   parameter int                   WORD_SIZE   = 32,
   parameter logic [WORD_SIZE-1:0] BASE_ADDR   = '0,
   parameter int                   DEPTH_WORDS = 1024
) (
   input  logic                           i_Clk,
   input  logic                           i_Reset,
   input  logic                           i_Flush,
   input  logic                           i_Valid,
   output logic                           o_Ready,
   input  logic [1:0]                     i_Format,
   input  logic [4:0]                     i_Rd,
   input  logic [4:0]                     i_Rs1,
   input  logic [4:0]                     i_Rs2,
   input  logic [2:0]                     i_Funct3,
   input  logic [WORD_SIZE-1:0]           i_Imm,
   output logic                           o_MemWrite,
   input  logic                           i_MemReady,
   output logic [WORD_SIZE-1:0]           o_MemAddress,
   output logic [WORD_SIZE-1:0]           o_MemData,
   output logic [$clog2(DEPTH_WORDS):0]   o_Count,
   output logic                           o_Wrapped,
   output logic                           o_Error
);

   localparam int IDX_W   = $clog2(DEPTH_WORDS);
   localparam int COUNT_W = IDX_W + 1;

   // Opcode values of the OPCODES_DEFINES set.
   localparam logic [6:0] OP_I_TYPE   = 7'b0010011;
   localparam logic [6:0] OP_I_L_TYPE = 7'b0000011;
   localparam logic [6:0] OP_S_TYPE   = 7'b0100011;
   localparam logic [6:0] OP_B_TYPE   = 7'b1100011;

   typedef enum logic [1:0] {
      FMT_I   = 2'b00,
      FMT_I_L = 2'b01,
      FMT_S   = 2'b10,
      FMT_B   = 2'b11
   } format_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [WORD_SIZE-1:0] data_q;
   logic [IDX_W-1:0]     idx_q;
   logic [COUNT_W-1:0]   count_q;
   logic                 wrapped_q;

   logic [31:0]          enc_word;
   logic [11:0]          m;
   logic                 imm_ok;
   logic                 mem_accept;
   logic                 load;

   // ---------------------------------------------------------------------------
   // Immediate range handling
   // ---------------------------------------------------------------------------
`ifdef IMM_RANGE_CHECK_EN
   logic                 err_set;
   logic                 error_q;

   // The immediate fits in 12 signed bits only when bits [W-1:11] are all copies
   // of the sign bit.
   assign imm_ok  = (&i_Imm[WORD_SIZE-1:11]) | ~(|i_Imm[WORD_SIZE-1:11]);
   // A rejected request still completes its handshake, so this uses o_Ready.
   assign err_set = i_Valid & o_Ready & ~imm_ok;

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         error_q <= 1'b0;
      end else if (i_Flush) begin
         error_q <= 1'b0;
      end else if (err_set) begin
         error_q <= 1'b1;
      end
   end

   assign o_Error = error_q;
`else
   logic unused_imm_hi;

   // Silent truncation: only the low 12 bits of i_Imm are used.
   assign imm_ok        = 1'b1;
   assign unused_imm_hi = ^i_Imm[WORD_SIZE-1:12];
   assign o_Error       = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Field packing
   // ---------------------------------------------------------------------------
   assign m = i_Imm[11:0];

   // NOTE: every output of a combinational block gets a default before the
   // case, so that no path leaves it unassigned and infers a latch.
   always_comb begin
      enc_word = '0;
      case (format_e'(i_Format))
         FMT_I:   enc_word = {m, i_Rs1, i_Funct3, i_Rd, OP_I_TYPE};
         FMT_I_L: enc_word = {m, i_Rs1, i_Funct3, i_Rd, OP_I_L_TYPE};
         FMT_S:   enc_word = {m[11:5], i_Rs2, i_Rs1, i_Funct3, m[4:0], OP_S_TYPE};
         // The B immediate is in halfword units: m[10] goes to bit 7 and
         // m[9:4] to bits [30:25], matching the generator's {31,7,30:25,11:8}.
         FMT_B:   enc_word = {m[11], m[9:4], i_Rs2, i_Rs1, i_Funct3,
                              m[3:0], m[10], OP_B_TYPE};
         default: enc_word = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Buffer FSM: next state and handshakes
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      o_Ready    = 1'b0;
      mem_accept = 1'b0;
      load       = 1'b0;
      o_MemWrite = (state_q == ST_FULL);

      if (i_Flush) begin
         // A flush overrides everything else. A word offered in this cycle is
         // forgotten, even if the memory takes it.
         state_d = ST_EMPTY;
      end else begin
         o_Ready    = (state_q == ST_EMPTY) || i_MemReady;
         mem_accept = (state_q == ST_FULL) && i_MemReady;
         load       = i_Valid && o_Ready && imm_ok;
         if (load) begin
            state_d = ST_FULL;
         end else if (mem_accept) begin
            state_d = ST_EMPTY;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State, data buffer, address counter and status
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is updated only with non-blocking assignments, so
   // every register samples values from before the clock edge.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q   <= ST_EMPTY;
         // NOTE: the data buffer is a single register, not a memory array.
         // Resetting it is cheap and gives the documented o_MemData = 0.
         data_q    <= '0;
         idx_q     <= '0;
         count_q   <= '0;
         wrapped_q <= 1'b0;
      end else if (i_Flush) begin
         state_q   <= ST_EMPTY;
         data_q    <= '0;
         idx_q     <= '0;
         count_q   <= '0;
         wrapped_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            data_q <= WORD_SIZE'(enc_word);
         end
         if (mem_accept) begin
            // DEPTH_WORDS is a power of two, so the word index wraps by itself.
            idx_q <= idx_q + 1'b1;
            if (&idx_q) begin
               wrapped_q <= 1'b1;
            end
            if (count_q != COUNT_W'(DEPTH_WORDS)) begin
               count_q <= count_q + 1'b1;
            end
         end
      end
   end

   // The buffered word is always written at the current counter position. A
   // word loaded alongside a memory accept therefore sees the advanced address.
   assign o_MemAddress = BASE_ADDR + WORD_SIZE'({idx_q, 2'b00});
   assign o_MemData    = data_q;
   assign o_Count      = count_q;
   assign o_Wrapped    = wrapped_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Self-checking bench for instr_encoder. Two instances share all inputs:
//   dut       DEPTH_WORDS = 1024, used for the scoreboard and most checks
//   dut_small DEPTH_WORDS = 4, used for the wrap and saturation checks
// The expected words are pushed to a queue when a request is accepted. They
// are popped and compared when the memory takes a word.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

   localparam logic [31:0] BASE = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        valid;
   logic [1:0]  format;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] imm;
   logic        mem_ready;

   logic        ready,  ready_s;
   logic        mem_write, mem_write_s;
   logic [31:0] mem_addr, mem_addr_s;
   logic [31:0] mem_data, mem_data_s;
   logic [10:0] count;
   logic [2:0]  count_s;
   logic        wrapped, wrapped_s;
   logic        error, error_s;

   int vectors     = 0;
   int miscompares = 0;
   int n_writes    = 0;
   int exp_idx     = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   instr_encoder #(.WORD_SIZE(32), .BASE_ADDR(BASE), .DEPTH_WORDS(1024)) dut (
      .i_Clk(clk), .i_Reset(rst), .i_Flush(flush), .i_Valid(valid), .o_Ready(ready),
      .i_Format(format), .i_Rd(rd), .i_Rs1(rs1), .i_Rs2(rs2), .i_Funct3(funct3),
      .i_Imm(imm), .o_MemWrite(mem_write), .i_MemReady(mem_ready),
      .o_MemAddress(mem_addr), .o_MemData(mem_data), .o_Count(count),
      .o_Wrapped(wrapped), .o_Error(error)
   );

   instr_encoder #(.WORD_SIZE(32), .BASE_ADDR(BASE), .DEPTH_WORDS(4)) dut_small (
      .i_Clk(clk), .i_Reset(rst), .i_Flush(flush), .i_Valid(valid), .o_Ready(ready_s),
      .i_Format(format), .i_Rd(rd), .i_Rs1(rs1), .i_Rs2(rs2), .i_Funct3(funct3),
      .i_Imm(imm), .o_MemWrite(mem_write_s), .i_MemReady(mem_ready),
      .o_MemAddress(mem_addr_s), .o_MemData(mem_data_s), .o_Count(count_s),
      .o_Wrapped(wrapped_s), .o_Error(error_s)
   );

   // ---------------------------------------------------------------------------
   // Reference model: encoder and immediate generator
   // ---------------------------------------------------------------------------
   function automatic logic [31:0] encode(input logic [1:0] f, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [2:0] f3, input logic [31:0] im);
      logic [11:0] mm;
      mm = im[11:0];
      case (f)
         2'b00:   return {mm, s1, f3, d, 7'h13};
         2'b01:   return {mm, s1, f3, d, 7'h03};
         2'b10:   return {mm[11:5], s2, s1, f3, mm[4:0], 7'h23};
         default: return {mm[11], mm[9:4], s2, s1, f3, mm[3:0], mm[10], 7'h63};
      endcase
   endfunction

   function automatic logic [31:0] imm_gen(input logic [31:0] w);
      logic [11:0] x;
      case (w[6:0])
         7'h23:   x = {w[31:25], w[11:7]};
         7'h63:   x = {w[31], w[7], w[30:25], w[11:8]};
         default: x = w[31:20];
      endcase
      return {{20{x[11]}}, x};
   endfunction

   function automatic logic imm_in_range(input logic [31:0] im);
`ifdef IMM_RANGE_CHECK_EN
      return (im[31:11] == '0) || (im[31:11] == '1);
`else
      return 1'b1;
`endif
   endfunction

   // ---------------------------------------------------------------------------
   // Scoreboard monitor, sampling mid-cycle
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      if (rst || flush) begin
         sb.delete();
         exp_idx = 0;
      end else begin
         // Pop first: in a full-throughput cycle the word written is the older one.
         if (mem_write && mem_ready) begin
            exp_t e;
            vectors++;
            n_writes++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL sb_unexpected_write: got addr=%h data=%h, expected no write",
                        mem_addr, mem_data);
            end else begin
               e = sb.pop_front();
               if (mem_data !== e.data || mem_addr !== e.addr) begin
                  miscompares++;
                  $display("FAIL sb_write: got addr=%h data=%h, expected addr=%h data=%h",
                           mem_addr, mem_data, e.addr, e.data);
               end
            end
         end
         if (valid && ready && imm_in_range(imm)) begin
            exp_t n;
            n.addr = BASE + 32'(4 * (exp_idx % 1024));
            n.data = encode(format, rd, rs1, rs2, funct3, imm);
            sb.push_back(n);
            exp_idx++;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] f, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im);
      valid  = 1'b1;
      format = f;
      rd     = d;
      rs1    = s1;
      rs2    = s2;
      funct3 = f3;
      imm    = im;
   endtask

   task automatic do_flush();
      valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; valid = 1'b0; mem_ready = 1'b0;
      format = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; imm = '0;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      vectors++;
      if (ready !== 1'b1 || mem_write !== 1'b0 || mem_addr !== BASE || mem_data !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_handshake: got ready=%b mw=%b addr=%h data=%h, expected 1 0 %h 0",
                  ready, mem_write, mem_addr, mem_data, BASE);
      end
      vectors++;
      if (count !== 11'd0 || wrapped !== 1'b0 || error !== 1'b0 || count_s !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_status: got count=%0d wrapped=%b error=%b count_s=%0d, expected 0 0 0 0",
                  count, wrapped, error, count_s);
      end
   endtask

   task automatic test_i_type();
      mem_ready = 1'b1;
      drive(2'b00, 5'd1, 5'd2, 5'h1F, 3'b000, 32'hFFFF_FFFF);
      tick();
      valid = 1'b0;
      vectors++;
      if (mem_write !== 1'b1 || mem_data !== 32'hFFF1_0093 || mem_addr !== BASE) begin
         miscompares++;
         $display("FAIL i_type_word: got mw=%b data=%h addr=%h, expected 1 fff10093 %h",
                  mem_write, mem_data, mem_addr, BASE);
      end
      vectors++;
      if (imm_gen(mem_data) !== 32'hFFFF_FFFF) begin
         miscompares++;
         $display("FAIL i_type_roundtrip: got %h, expected ffffffff", imm_gen(mem_data));
      end
      tick();
   endtask

   task automatic test_s_b_type();
      drive(2'b10, 5'h1F, 5'd2, 5'd5, 3'b010, 32'h0000_07FF);
      tick();
      valid = 1'b0;
      vectors++;
      if (mem_data !== 32'h7E51_2FA3 || mem_addr !== BASE + 32'd4) begin
         miscompares++;
         $display("FAIL s_type_word: got data=%h addr=%h, expected 7e512fa3 %h",
                  mem_data, mem_addr, BASE + 32'd4);
      end
      vectors++;
      if (imm_gen(mem_data) !== 32'h0000_07FF) begin
         miscompares++;
         $display("FAIL s_type_roundtrip: got %h, expected 000007ff", imm_gen(mem_data));
      end
      tick();
      drive(2'b11, 5'h0A, 5'd1, 5'd2, 3'b000, 32'hFFFF_F801);
      tick();
      valid = 1'b0;
      vectors++;
      if (mem_data !== 32'h8020_8163 || mem_addr !== BASE + 32'd8) begin
         miscompares++;
         $display("FAIL b_type_word: got data=%h addr=%h, expected 80208163 %h",
                  mem_data, mem_addr, BASE + 32'd8);
      end
      vectors++;
      if (imm_gen(mem_data) !== 32'hFFFF_F801) begin
         miscompares++;
         $display("FAIL b_type_roundtrip: got %h, expected fffff801", imm_gen(mem_data));
      end
      tick();
      vectors++;
      if (count !== 11'd3) begin
         miscompares++;
         $display("FAIL count_after_three: got %0d, expected 3", count);
      end
   endtask

   task automatic test_back_to_back();
      int w0;
      do_flush();
      mem_ready = 1'b1;
      w0 = n_writes;
      for (int i = 0; i < 8; i++) begin
         logic [11:0] r;
         r = 12'($urandom);
         drive(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom),
               3'($urandom), {{20{r[11]}}, r});
         #1;
         vectors++;
         if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready cycle %0d: got %b, expected 1", i, ready);
         end
         tick();
      end
      valid = 1'b0;
      tick();
      vectors++;
      if (count !== 11'd8 || n_writes - w0 !== 8 || mem_addr !== BASE + 32'd32 || mem_write !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_totals: got count=%0d writes=%0d addr=%h mw=%b, expected 8 8 %h 0",
                  count, n_writes - w0, mem_addr, mem_write, BASE + 32'd32);
      end
   endtask

   task automatic test_stall();
      int          w0;
      logic [31:0] held;
      do_flush();
      w0 = n_writes;
      mem_ready = 1'b0;
      drive(2'b01, 5'd7, 5'd8, 5'd0, 3'b010, 32'h0000_0123);
      held = encode(2'b01, 5'd7, 5'd8, 5'd0, 3'b010, 32'h0000_0123);
      tick();
      drive(2'b10, 5'd0, 5'd3, 5'd4, 3'b001, 32'hFFFF_FF80);
      for (int i = 0; i < 5; i++) begin
         #1;
         vectors++;
         if (ready !== 1'b0 || mem_write !== 1'b1 || mem_data !== held || mem_addr !== BASE) begin
            miscompares++;
            $display("FAIL stall_hold cycle %0d: got ready=%b mw=%b data=%h addr=%h, expected 0 1 %h %h",
                     i, ready, mem_write, mem_data, mem_addr, held, BASE);
         end
         tick();
      end
      mem_ready = 1'b1;
      tick();
      valid = 1'b0;
      tick();
      vectors++;
      if (n_writes - w0 !== 2 || count !== 11'd2 || mem_write !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_release: got writes=%0d count=%0d mw=%b, expected 2 2 0",
                  n_writes - w0, count, mem_write);
      end
   endtask

   task automatic test_wrap_flush();
      do_flush();
      mem_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         drive(2'b00, 5'(k + 1), 5'd3, 5'd0, 3'b000, 32'(k));
         tick();
         if (k == 3) begin
            vectors++;
            if (wrapped_s !== 1'b0) begin
               miscompares++;
               $display("FAIL wrap_early: got wrapped_s=%b, expected 0", wrapped_s);
            end
         end
      end
      valid = 1'b0;
      vectors++;
      if (mem_addr_s !== BASE || wrapped_s !== 1'b1 || count_s !== 3'd4 || mem_addr !== BASE + 32'd16) begin
         miscompares++;
         $display("FAIL wrap_fifth: got addr_s=%h wrapped_s=%b count_s=%0d addr=%h, expected %h 1 4 %h",
                  mem_addr_s, wrapped_s, count_s, mem_addr, BASE, BASE + 32'd16);
      end
      tick();
      vectors++;
      if (count_s !== 3'd4 || count !== 11'd5 || wrapped !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap_saturate: got count_s=%0d count=%0d wrapped=%b, expected 4 5 0",
                  count_s, count, wrapped);
      end
      // Fill the buffer, then flush with a new request pending.
      mem_ready = 1'b0;
      drive(2'b00, 5'd9, 5'd9, 5'd0, 3'b000, 32'd9);
      tick();
      drive(2'b10, 5'd0, 5'd1, 5'd1, 3'b000, 32'd4);
      mem_ready = 1'b1;
      flush = 1'b1;
      #1;
      vectors++;
      if (ready !== 1'b0 || ready_s !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_ready: got ready=%b ready_s=%b, expected 0 0", ready, ready_s);
      end
      tick();
      flush = 1'b0;
      valid = 1'b0;
      #1;
      vectors++;
      if (mem_write !== 1'b0 || count !== 11'd0 || count_s !== 3'd0 || wrapped_s !== 1'b0 ||
          mem_addr !== BASE || mem_addr_s !== BASE || error !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_clear: got mw=%b count=%0d count_s=%0d wrapped_s=%b addr=%h addr_s=%h err=%b, expected 0 0 0 0 %h %h 0",
                  mem_write, count, count_s, wrapped_s, mem_addr, mem_addr_s, error, BASE, BASE);
      end
      tick();
   endtask

   task automatic test_imm_range();
      do_flush();
      mem_ready = 1'b1;
      drive(2'b00, 5'd4, 5'd5, 5'd0, 3'b000, 32'd2048);
      #1;
      vectors++;
      if (ready !== 1'b1) begin
         miscompares++;
         $display("FAIL range_ready: got %b, expected 1", ready);
      end
      tick();
      valid = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
      vectors++;
      if (mem_write !== 1'b0 || error !== 1'b1 || count !== 11'd0 || mem_addr !== BASE) begin
         miscompares++;
         $display("FAIL range_reject: got mw=%b err=%b count=%0d addr=%h, expected 0 1 0 %h",
                  mem_write, error, count, mem_addr, BASE);
      end
      tick();
      vectors++;
      if (error !== 1'b1) begin
         miscompares++;
         $display("FAIL range_sticky: got %b, expected 1", error);
      end
      do_flush();
      vectors++;
      if (error !== 1'b0) begin
         miscompares++;
         $display("FAIL range_flush: got %b, expected 0", error);
      end
`else
      vectors++;
      if (mem_write !== 1'b1 || mem_data[31:20] !== 12'h800 || error !== 1'b0) begin
         miscompares++;
         $display("FAIL range_truncate: got mw=%b imm=%h err=%b, expected 1 800 0",
                  mem_write, mem_data[31:20], error);
      end
      tick();
`endif
   endtask

   task automatic test_async_reset();
      mem_ready = 1'b0;
      drive(2'b11, 5'd0, 5'd6, 5'd7, 3'b001, 32'd12);
      tick();
      valid = 1'b0;
      vectors++;
      if (mem_write !== 1'b1) begin
         miscompares++;
         $display("FAIL areset_pre: got mw=%b, expected 1", mem_write);
      end
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (mem_write !== 1'b0 || mem_data !== 32'h0 || mem_addr !== BASE || ready !== 1'b1) begin
         miscompares++;
         $display("FAIL areset_discard: got mw=%b data=%h addr=%h ready=%b, expected 0 0 %h 1",
                  mem_write, mem_data, mem_addr, ready, BASE);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_i_type();
      test_s_b_type();
      test_back_to_back();
      test_stall();
      test_wrap_flush();
      test_imm_range();
      test_async_reset();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL sb_leftover: got %0d pending words, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Encodes RV32 I, I-load, S and B instructions from their fields into 32-bit instruction words and streams them into instruction memory through a one-entry output buffer with a write-address counter. It is the inverse of the pipeline's immediate generator: the 12-bit immediate taken in here is exactly the value that generator extracts from the produced word, including B-type, which is in halfword units. It sits between the test/boot program loader and the instruction memory write port.

## Interface
- WORD_SIZE, 32, instruction/data/address width
- BASE_ADDR, 0, byte address of the first word written
- DEPTH_WORDS, 1024, memory depth in words; power of two
- i_Clk  in  1  clock, rising edge
- i_Reset  in  1  asynchronous, active-high reset
- i_Flush  in  1  synchronous clear of buffer, address, count, error
- i_Valid  in  1  encode request valid
- o_Ready  out  1  request accepted when i_Valid && o_Ready
- i_Format  in  2  00 = OP_I_TYPE, 01 = OP_I_L_TYPE, 10 = OP_S_TYPE, 11 = OP_B_TYPE
- i_Rd, i_Rs1, i_Rs2  in  5 each  register fields
- i_Funct3  in  3  funct3 field
- i_Imm  in  WORD_SIZE  signed immediate; B-type in halfword units
- o_MemWrite  out  1  buffered word valid toward memory
- i_MemReady  in  1  memory accepts the word when o_MemWrite && i_MemReady
- o_MemAddress  out  WORD_SIZE  byte address of the buffered word
- o_MemData  out  WORD_SIZE  encoded instruction
- o_Count  out  clog2(DEPTH_WORDS)+1  words written since reset/flush, saturating
- o_Wrapped  out  1  sticky; address has wrapped at least once
- o_Error  out  1  sticky; immediate out of range (see Configuration)

## Operation
- Opcode [6:0] comes from the OPCODES_DEFINES macros for i_Format.
- Let m = i_Imm[11:0].
- I / I-load: {m[11:0], rs1, funct3, rd, opcode}.
- S: {m[11:5], rs2, rs1, funct3, m[4:0], opcode}.
- B: [31] = m[11], [30:25] = m[9:4], [24:20] = rs2, [19:15] = rs1, [14:12] = funct3, [11:8] = m[3:0], [7] = m[10], [6:0] = opcode.
- Unused fields are ignored: rs2 for I-formats, rd for S and B.
- One-entry buffer, states EMPTY and FULL:
  - EMPTY: o_Ready = 1. On accept, go to FULL and latch data and address.
  - FULL: o_MemWrite = 1 and o_Ready = i_MemReady. On a memory accept without a new request, go to EMPTY. On a memory accept with a simultaneous request, stay FULL and load the new word. This gives full throughput at one word per cycle.
- Address counter:
  - Starts at BASE_ADDR.
  - Advances by 4 on each memory accept.
  - After BASE_ADDR + 4*(DEPTH_WORDS-1) it returns to BASE_ADDR and sets o_Wrapped.
- o_Count increments on each memory accept and saturates at DEPTH_WORDS.
- i_Flush:
  - Has priority over all other inputs.
  - Empties the buffer, resets the address to BASE_ADDR, and clears o_Count, o_Wrapped and o_Error.
  - A request presented in the flush cycle is not accepted (o_Ready = 0 that cycle).
  - A word being offered in the flush cycle is dropped from the encoder's view, whatever i_MemReady is.

## Timing
- Reset values: buffer EMPTY, o_Ready = 1, o_MemWrite = 0, o_MemAddress = BASE_ADDR, o_MemData = 0, o_Count = 0, o_Wrapped = 0, o_Error = 0.
- Latency: a request accepted at edge N drives o_MemWrite, o_MemData and o_MemAddress from N until the memory accepts it.
- o_MemData and o_MemAddress stay stable while o_MemWrite = 1 and i_MemReady = 0.
- o_Ready is combinational from i_MemReady, i_Flush and state only; it does not depend on i_Valid.
- Reset asserted mid-transfer discards the buffered word immediately (asynchronous).

## Configuration
- IMM_RANGE_CHECK_EN defined:
  - A request with i_Imm[31:11] not all equal is still handshaken (o_Ready behaves normally) but is not buffered.
  - o_Error is set the next cycle.
  - The address and o_Count do not advance.
- Undefined: i_Imm[11:0] is used as-is (silent truncation), and o_Error is tied to 0.

## Test plan
- I-type, funct3 = 000, rd = 1, rs1 = 2, imm = -1, i_MemReady = 1 -> one cycle later o_MemData = 32'hFFF10093 at o_MemAddress = BASE_ADDR; the immediate generator returns 32'hFFFFFFFF.
- S-type, funct3 = 010, rs1 = 2, rs2 = 5, imm = 12'h7FF -> 32'h7E512FA3. B-type, funct3 = 000, rs1 = 1, rs2 = 2, imm = 12'h801 -> 32'h80208163. For both, the generator round-trips the immediate exactly.
- Back-to-back valids with i_MemReady = 1 for 8 cycles -> 8 writes at BASE_ADDR..BASE_ADDR+28, o_Ready never drops, o_Count = 8.
- i_MemReady held 0 for 5 cycles with the buffer FULL -> o_Ready = 0, data and address held; on release the word is written once, with no duplicate and no loss.
- DEPTH_WORDS = 4, 5 writes -> the fifth goes to BASE_ADDR, o_Wrapped = 1, o_Count = 4. Then assert i_Flush with i_Valid = 1 -> the request is not accepted and all status is cleared.
- With IMM_RANGE_CHECK_EN defined, imm = 2048 -> the request is handshaken, nothing is written, and o_Error = 1. Without the macro -> the word is written with imm field 12'h800, and o_Error = 0.
